// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field layout, FSM states and the byte-enable store merge.
package timer_dev_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // MODE 1x is not decoded and therefore behaves as one-shot.
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Data-memory bus slice seen by the timer: MEM-stage store strobe with byte
// enables and a combinational read-data return.
interface timer_dev_if;

    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output be, output wdata, input rdata);
    modport slave  (input addr, input we, input be, input wdata, output rdata);

endinterface

// File: rtl/timer_dev.sv
// Countdown timer with one-shot / auto-reload modes and a maskable,
// registered interrupt request.
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus,
    output logic        irq
);

    state_e      state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;

    logic        en, reload, ctrl_wr, preset_wr;
    logic        cnt_load, cnt_dec, cnt_zero, pend_set, pend_clr, en_clr;

    assign en        = ctrl_q[CTRL_EN];
    assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign ctrl_wr   = bus.we && (bus.addr == OFF_CTRL);
    assign preset_wr = bus.we && (bus.addr == OFF_PRESET);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!en)                   state_d = ST_IDLE;
                else if (count_q <= 32'd1) state_d = ST_INT;
            end
            ST_INT:  state_d = reload ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_zero = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        en_clr   = 1'b0;
        unique case (state_q)
            ST_LOAD: cnt_load = 1'b1;
            ST_CNT: begin
                if (en && count_q <= 32'd1) begin
                    cnt_zero = 1'b1;
                    pend_set = 1'b1;
                end else if (en) begin
                    cnt_dec = 1'b1;
                end
            end
            ST_INT: begin
                if (reload) pend_clr = 1'b1;
                else        en_clr   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (en_clr) ctrl_d[CTRL_EN] = 1'b0;
        // A CTRL store merges against the pre-clear value so it overrides en_clr.
        if (ctrl_wr) ctrl_d = be_merge(ctrl_q, bus.wdata, bus.be) & CTRL_WMASK;

        preset_d = preset_wr ? be_merge(preset_q, bus.wdata, bus.be) : preset_q;

        count_d = count_q;
        if (cnt_load)      count_d = preset_q;
        else if (cnt_zero) count_d = '0;
        else if (cnt_dec)  count_d = count_q - 32'd1;

        // A terminal count in the same cycle as a CTRL store is not lost.
        pending_d = pending_q;
        if (pend_clr || ctrl_wr) pending_d = 1'b0;
        if (pend_set)            pending_d = 1'b1;

        irq_d = pending_q & ctrl_q[CTRL_IM];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (bus.addr)
            OFF_CTRL:   bus.rdata = ctrl_q;
            OFF_PRESET: bus.rdata = preset_q;
            OFF_COUNT:  bus.rdata = count_q;
            OFF_RSVD:   bus.rdata = '0;
            default:    bus.rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register access, one-shot and auto-reload
// timing, pause/reload behaviour and reset priority.
module tb_timer_dev;
    import timer_dev_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    timer_dev_if bus ();

    timer_dev u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = be;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.be    = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        seen_zero, seen_three;

        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.be    = '0;
        bus.wdata = '0;
        tick(3);
        rst = 1'b0;
        tick();

        // Reset state
        chk_rd("rst_ctrl",   OFF_CTRL,   32'h0);
        chk_rd("rst_preset", OFF_PRESET, 32'h0);
        chk_rd("rst_count",  OFF_COUNT,  32'h0);
        chk_rd("rst_rsvd",   OFF_RSVD,   32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Partial stores, read-only COUNT, reserved slot, CTRL masking
        store(OFF_PRESET, 32'h1122_3344);
        chk_rd("preset_full", OFF_PRESET, 32'h1122_3344);
        store(OFF_PRESET, 32'hAABB_CCDD, 4'b0010);
        chk_rd("preset_be1", OFF_PRESET, 32'h1122_CC44);
        chk_rd("preset_model", OFF_PRESET, be_merge(32'h1122_3344, 32'hAABB_CCDD, 4'b0010));
        store(OFF_COUNT, 32'hFFFF_FFFF);
        chk_rd("count_ro", OFF_COUNT, 32'h0);
        store(OFF_RSVD, 32'hFFFF_FFFF);
        chk_rd("rsvd_ro", OFF_RSVD, 32'h0);
        store(OFF_CTRL, 32'hFFFF_FFF0);
        chk_rd("ctrl_mask", OFF_CTRL, 32'h0);

        // One-shot, PRESET=5
        store(OFF_PRESET, 32'd5);
        store(OFF_CTRL, 32'h9);                 // edge t
        chk_rd("os_t0_count", OFF_COUNT, 32'd0);
        tick();                                 // t+1: LOAD
        chk_rd("os_t1_count", OFF_COUNT, 32'd0);
        for (int unsigned k = 0; k < 6; k++) begin
            tick();                             // t+2 .. t+7
            chk_rd($sformatf("os_count_%0d", k), OFF_COUNT, 32'd5 - k);
            check($sformatf("os_irq_lo_%0d", k), {31'b0, irq}, 32'h0);
        end
        tick();                                 // t+8
        check("os_irq_rise", {31'b0, irq}, 32'h1);
        chk_rd("os_en_cleared", OFF_CTRL, 32'h8);
        tick(3);
        check("os_irq_held", {31'b0, irq}, 32'h1);
        chk_rd("os_count_hold", OFF_COUNT, 32'd0);
        store(OFF_CTRL, 32'h0);
        tick();
        check("os_irq_cleared", {31'b0, irq}, 32'h0);

        // Auto-reload, PRESET=3: pulses at t+6, t+11, t+16
        store(OFF_PRESET, 32'd3);
        store(OFF_CTRL, 32'hB);                 // edge t
        for (int unsigned k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("ar_irq_%0d", k), {31'b0, irq},
                  {31'b0, (k >= 6) && ((k - 6) % 5 == 0)});
            if (k == 7) chk_rd("ar_reloaded", OFF_COUNT, 32'd3);
        end

        // IM=0: irq masked while the counter keeps cycling
        store(OFF_CTRL, 32'h3);
        seen_zero  = 1'b0;
        seen_three = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            tick();
            check($sformatf("ar_masked_%0d", k), {31'b0, irq}, 32'h0);
            rd(OFF_COUNT, d);
            if (d == 32'd0) seen_zero  = 1'b1;
            if (d == 32'd3) seen_three = 1'b1;
        end
        check("ar_cycles", {30'b0, seen_zero, seen_three}, 32'h3);
        store(OFF_CTRL, 32'h0);
        tick(3);

        // Pause at 7 and re-enable, PRESET=10
        store(OFF_PRESET, 32'd10);
        store(OFF_CTRL, 32'h1);                 // edge t
        tick(4);                                // t+4
        chk_rd("pause_pre", OFF_COUNT, 32'd8);
        store(OFF_CTRL, 32'h0);                 // t+5
        chk_rd("pause_at7", OFF_COUNT, 32'd7);
        tick(4);
        chk_rd("pause_hold", OFF_COUNT, 32'd7);
        store(OFF_CTRL, 32'h1);                 // edge u
        tick(2);                                // u+2
        chk_rd("reenable_reload", OFF_COUNT, 32'd10);
        store(OFF_CTRL, 32'h0);
        tick(3);

        // PRESET=0: terminal count on the first CNT cycle
        store(OFF_PRESET, 32'd0);
        store(OFF_CTRL, 32'h9);                 // edge v
        tick(3);                                // v+3
        check("p0_irq_lo", {31'b0, irq}, 32'h0);
        tick();                                 // v+4
        check("p0_irq_hi", {31'b0, irq}, 32'h1);
        store(OFF_CTRL, 32'h0);
        tick(2);

        // Reset mid-count against a simultaneous CTRL store
        store(OFF_PRESET, 32'd10);
        store(OFF_CTRL, 32'h9);
        tick(5);
        rst       = 1'b1;
        bus.addr  = OFF_CTRL;
        bus.wdata = 32'hF;
        bus.be    = 4'hF;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.be    = '0;
        rst       = 1'b0;
        chk_rd("rst2_ctrl",   OFF_CTRL,   32'h0);
        chk_rd("rst2_preset", OFF_PRESET, 32'h0);
        chk_rd("rst2_count",  OFF_COUNT,  32'h0);
        check("rst2_irq", {31'b0, irq}, 32'h0);
        tick(3);
        chk_rd("rst2_idle_count", OFF_COUNT, 32'h0);
        check("rst2_idle_irq", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer on the CPU data-memory bus, the responder side of the load/store path that the pipeline's MEM stage drives. Decodes word offsets, merges byte-enabled stores into three 32-bit registers, and serves combinational read data during the same MEM cycle. Counts down from a preset and raises an interrupt request toward the CPU's exception logic, in one-shot or auto-reload mode.

## Interface
- CTRL_WMASK, 32'h0000_000F: writable CTRL bits; all others are forced to 0.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  2  word offset (bus address bits [3:2]); the bridge decodes the base.
- we  input  1  store strobe, valid for one cycle.
- be  input  4  byte enables for the store; be[i] covers wdata[8i+7:8i].
- wdata  input  32  store data.
- rdata  output  32  read data, combinational from addr and current register state.
- irq  output  1  interrupt request, registered.

## Operation
- Registers by offset:
  - 0: CTRL. [0] EN, [2:1] MODE, [3] IM.
  - 1: PRESET.
  - 2: COUNT, read-only.
  - 3: reserved; reads 0, writes ignored.
- Store: each register byte with be[i]=1 takes the wdata byte, others keep their value. CTRL result is ANDed with CTRL_WMASK.
- MODE 00 is one-shot. MODE 01 is auto-reload. MODE 1x is treated as 00.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE, with COUNT frozen.
    - Else if COUNT<=1: COUNT <= 0, pending <= 1 -> INT.
    - Else COUNT <= COUNT-1.
  - INT, MODE 00: EN <= 0 -> IDLE. pending stays set until the next CTRL store.
  - INT, MODE 01: -> LOAD, and pending is cleared next cycle (one-cycle pulse).
- irq = pending & IM.
- Any store to CTRL clears pending.
- Simultaneous events:
  - A CTRL store in the same cycle as the INT-state EN clear: the store wins.
  - A PRESET store during CNT affects only the next LOAD.
  - A COUNT store is ignored.
  - PRESET=0 gives CNT -> INT on the first CNT cycle.

## Timing
- Reset values: CTRL, PRESET, COUNT, pending, irq all 0; state IDLE. rdata therefore reads 0 at every offset after reset.
- A store is visible in rdata the cycle after the we edge.
- Store EN=1 at edge t:
  - LOAD at t+1.
  - COUNT=PRESET after edge t+2.
  - COUNT reaches 0 after PRESET more edges.
  - irq asserts on the edge after COUNT reaches 0.
- Period in MODE 01: PRESET+2 cycles between irq pulses (for PRESET≥1).
- rst asserted mid-count returns everything to reset values on that edge. It overrides a simultaneous store.

## Structure
- Shared package contents:
  - Offset constants CTRL/PRESET/COUNT.
  - CTRL bit positions and the MODE encodings.
  - FSM state enum.
  - Byte-merge function (old, new, be).
- Single module; no sub-module. The byte merge is the package function, also reused by the bench's reference model.

## Test plan
- Reset, then read offsets 0–3 -> all 0; irq=0.
- Store PRESET=5, then CTRL=4'b1001 (EN, IM, MODE 00):
  - COUNT reads 5,4,3,2,1,0.
  - irq rises one cycle after 0 and stays high.
  - CTRL[0] reads 0.
  - A store CTRL=0 drops irq the next cycle.
- PRESET=3, CTRL=4'b1011 (auto-reload) -> one-cycle irq pulses every 5 cycles, repeating; IM=0 suppresses irq while COUNT keeps cycling.
- Partial store: PRESET=32'h1122_3344, then be=4'b0010 with wdata=32'hAABB_CCDD -> PRESET reads 32'h1122_CC44. A store to COUNT leaves it unchanged.
- Pause and limits:
  - Clear EN mid-count at COUNT=7 -> COUNT holds 7.
  - Re-enable -> reloads PRESET.
  - PRESET=0 with EN -> irq two cycles after LOAD.
- Assert rst during CNT with a simultaneous CTRL store -> all registers 0, state IDLE, irq 0.
